// File: rtl/iic_slave.sv
// I2C target modelled on a 24C02-style EEPROM: oversampled SCL/SDA, 7-bit address match,
// random write, current-address and random read with wrapping pointer auto-increment.
module iic_slave #(
  parameter logic [6:0]  DEV_ADDR = 7'h50,
  parameter int unsigned AW       = 4
) (
  input  logic          clk,
  input  logic          srst,
  input  logic          scl,
  input  logic          sda_in,
  output logic          sda_oe,
  output logic          busy,
  output logic          wr_pulse,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data
);
  localparam int unsigned Depth = 2 ** AW;

  typedef enum logic [2:0] {
    StIdle, StDev, StAckDev, StWaddr, StAckAddr, StWrite, StAckWr, StRead
  } state_e;

  state_e        r_state, w_state_d;
  logic          r_scl_s1, r_scl_s2, r_scl_h;
  logic          r_sda_s1, r_sda_s2, r_sda_h;
  logic [6:0]    r_shift;
  logic [7:0]    r_tx;
  logic [3:0]    r_cnt;
  logic          r_rw, r_ack_on;
  logic [AW-1:0] r_ptr;
  logic [7:0]    r_mem [Depth];
  logic          r_sda_oe, r_busy, r_wr_pulse;
  logic [AW-1:0] r_wr_addr;
  logic [7:0]    r_wr_data;

  logic          w_sda_oe_d, w_busy_d, w_wr_pulse_d;
  logic          w_scl_rise, w_scl_fall, w_start, w_stop, w_sda;
  logic          w_byte_done, w_ack_end, w_addr_match;
  logic [7:0]    w_byte;
  logic [AW-1:0] w_ptr_inc;

  always_ff @(posedge clk) begin
    if (srst) begin
      r_scl_s1 <= 1'b1;
      r_scl_s2 <= 1'b1;
      r_scl_h  <= 1'b1;
      r_sda_s1 <= 1'b1;
      r_sda_s2 <= 1'b1;
      r_sda_h  <= 1'b1;
    end else begin
      r_scl_s1 <= scl;
      r_scl_s2 <= r_scl_s1;
      r_scl_h  <= r_scl_s2;
      r_sda_s1 <= sda_in;
      r_sda_s2 <= r_sda_s1;
      r_sda_h  <= r_sda_s2;
    end
  end

  assign w_sda        = r_sda_s2;
  assign w_scl_rise   = r_scl_s2 & ~r_scl_h;
  assign w_scl_fall   = ~r_scl_s2 & r_scl_h;
  assign w_start      = r_scl_s2 & r_scl_h & r_sda_h & ~r_sda_s2;
  assign w_stop       = r_scl_s2 & r_scl_h & ~r_sda_h & r_sda_s2;
  assign w_byte       = {r_shift, w_sda};
  assign w_byte_done  = w_scl_rise & (r_cnt == 4'd7);
  assign w_ack_end    = w_scl_fall & r_ack_on;
  assign w_addr_match = (r_shift == DEV_ADDR);
  assign w_ptr_inc    = r_ptr + 1'b1;

  always_ff @(posedge clk) begin
    if (srst) r_state <= StIdle;
    else      r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    if (w_start) begin
      w_state_d = StDev;
    end else if (w_stop) begin
      w_state_d = StIdle;
    end else begin
      unique case (r_state)
        StIdle:    w_state_d = StIdle;
        StDev:     if (w_byte_done) w_state_d = w_addr_match ? StAckDev : StIdle;
        StAckDev:  if (w_ack_end) w_state_d = r_rw ? StRead : StWaddr;
        StWaddr:   if (w_byte_done) w_state_d = StAckAddr;
        StAckAddr: if (w_ack_end) w_state_d = StWrite;
        StWrite:   if (w_byte_done) w_state_d = StAckWr;
        StAckWr:   if (w_ack_end) w_state_d = StWrite;
        StRead:    if (w_scl_rise && r_cnt == 4'd9 && w_sda) w_state_d = StIdle;
        default:   w_state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    w_sda_oe_d   = r_sda_oe;
    w_busy_d     = r_busy;
    w_wr_pulse_d = 1'b0;
    if (w_start || w_stop) begin
      w_sda_oe_d = 1'b0;
    end else if (w_scl_fall) begin
      unique case (r_state)
        // First fall raises the ACK; second ends it and, for a read, drives bit 7.
        StAckDev, StAckAddr, StAckWr: begin
          if (!r_ack_on)                           w_sda_oe_d = 1'b1;
          else if (r_state == StAckDev && r_rw)    w_sda_oe_d = ~r_tx[7];
          else                                     w_sda_oe_d = 1'b0;
        end
        StRead:  w_sda_oe_d = (r_cnt < 4'd8) ? ~r_tx[7] : 1'b0;
        default: w_sda_oe_d = 1'b0;
      endcase
    end
    if (r_state == StWrite && w_byte_done && !w_start && !w_stop) w_wr_pulse_d = 1'b1;
    if (w_state_d == StIdle) begin
      w_busy_d = 1'b0;
    end else if (r_state == StDev && w_byte_done && w_addr_match && !w_start && !w_stop) begin
      w_busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      r_sda_oe   <= 1'b0;
      r_busy     <= 1'b0;
      r_wr_pulse <= 1'b0;
    end else begin
      r_sda_oe   <= w_sda_oe_d;
      r_busy     <= w_busy_d;
      r_wr_pulse <= w_wr_pulse_d;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      r_shift   <= '0;
      r_tx      <= '0;
      r_cnt     <= '0;
      r_rw      <= 1'b0;
      r_ack_on  <= 1'b0;
      r_ptr     <= '0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      for (int i = 0; i < Depth; i++) r_mem[i] <= '0;
    end else if (w_start || w_stop) begin
      r_cnt    <= '0;
      r_ack_on <= 1'b0;
    end else begin
      case (r_state)
        StDev, StWaddr, StWrite: begin
          if (w_scl_rise) begin
            r_shift <= {r_shift[5:0], w_sda};
            r_cnt   <= r_cnt + 4'd1;
            if (r_cnt == 4'd7) begin
              r_cnt <= '0;
              if (r_state == StDev) begin
                r_rw <= w_sda;
                r_tx <= r_mem[r_ptr];
              end else if (r_state == StWaddr) begin
                r_ptr <= w_byte[AW-1:0];
              end else begin
                r_mem[r_ptr] <= w_byte;
                r_wr_addr    <= r_ptr;
                r_wr_data    <= w_byte;
                r_ptr        <= w_ptr_inc;
              end
            end
          end
        end
        StAckDev, StAckAddr, StAckWr: begin
          if (w_scl_fall) begin
            r_ack_on <= ~r_ack_on;
            if (r_ack_on && r_state == StAckDev && r_rw) begin
              r_tx  <= {r_tx[6:0], 1'b0};
              r_cnt <= 4'd1;
            end
          end
        end
        // r_cnt counts bits driven; 9 means waiting for the master's ACK/NACK.
        StRead: begin
          if (w_scl_fall && r_cnt < 4'd8) begin
            r_tx  <= {r_tx[6:0], 1'b0};
            r_cnt <= r_cnt + 4'd1;
          end else if (w_scl_fall && r_cnt == 4'd8) begin
            r_cnt <= 4'd9;
          end else if (w_scl_rise && r_cnt == 4'd9 && !w_sda) begin
            r_ptr <= w_ptr_inc;
            r_tx  <= r_mem[w_ptr_inc];
            r_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign sda_oe   = r_sda_oe;
  assign busy     = r_busy;
  assign wr_pulse = r_wr_pulse;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;

endmodule

// File: tb/tb_iic_slave.sv
// Directed bench for iic_slave: a bit-banged I2C master on an open-drain bus, with
// scoreboard queues for committed writes and read-back bytes.
module tb_iic_slave;
  localparam int unsigned AW = 4;
  localparam int Q = 50;  // quarter SCL period; SCL half-period is 10 clk

  logic          clk = 1'b0;
  logic          srst = 1'b1;
  logic          m_scl = 1'b1;
  logic          m_sda = 1'b1;
  logic          sda_bus;
  logic          sda_oe, busy, wr_pulse;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;

  int            n_tests = 0;
  int            n_fail = 0;
  logic [11:0]   wr_q[$];
  logic [7:0]    rd_q[$];
  logic          prev_pulse = 1'b0;
  logic          watch_oe = 1'b0;
  logic          oe_seen = 1'b0;
  logic          ack;

  assign sda_bus = m_sda & ~sda_oe;

  iic_slave #(
    .DEV_ADDR(7'h50),
    .AW      (AW)
  ) u_dut (
    .clk     (clk),
    .srst    (srst),
    .scl     (m_scl),
    .sda_in  (sda_bus),
    .sda_oe  (sda_oe),
    .busy    (busy),
    .wr_pulse(wr_pulse),
    .wr_addr (wr_addr),
    .wr_data (wr_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 'h%0h required 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_start();
    m_sda = 1'b1; #(Q);
    m_scl = 1'b1; #(Q);
    m_sda = 1'b0; #(Q);
    m_scl = 1'b0; #(Q);
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; #(Q);
    m_scl = 1'b1; #(Q);
    m_sda = 1'b1; #(2 * Q);
  endtask

  task automatic send_bit(input logic b);
    m_sda = b;    #(Q);
    m_scl = 1'b1; #(2 * Q);
    m_scl = 1'b0; #(Q);
  endtask

  task automatic recv_bit(output logic b);
    m_sda = 1'b1; #(Q);
    m_scl = 1'b1; #(Q);
    b = sda_bus;  #(Q);
    m_scl = 1'b0; #(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic a);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(a);
  endtask

  task automatic read_check(input string tag, input logic mack);
    logic [7:0] d;
    logic [7:0] exp;
    for (int i = 7; i >= 0; i--) recv_bit(d[i]);
    send_bit(mack);
    exp = (rd_q.size() != 0) ? rd_q.pop_front() : 8'hxx;
    check(tag, 32'(d), 32'(exp));
  endtask

  // START, write-address the device, set the pointer; leaves SCL low after the ACK.
  task automatic set_ptr(input string tag, input logic [7:0] a);
    logic k;
    bus_start();
    write_byte(8'hA0, k);
    check({tag, "_dev_ack"}, 32'(k), 0);
    write_byte(a, k);
    check({tag, "_addr_ack"}, 32'(k), 0);
  endtask

  always @(negedge clk) begin
    if (wr_pulse) begin
      check("wr_pulse_width", 32'(prev_pulse), 0);
      check("wr_expected", 32'(wr_q.size() != 0), 1);
      if (wr_q.size() != 0) check("wr_commit", 32'({wr_addr, wr_data}), 32'(wr_q.pop_front()));
    end
    prev_pulse <= wr_pulse;
    if (watch_oe && sda_oe) oe_seen = 1'b1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout, required $finish before it");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_sda_oe", 32'(sda_oe), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_wr_pulse", 32'(wr_pulse), 0);
    srst = 1'b0;
    repeat (4) @(negedge clk);

    // Read of address 0 after reset.
    set_ptr("rd0", 8'h00);
    bus_start();
    write_byte(8'hA1, ack);
    check("rd0_rd_ack", 32'(ack), 0);
    rd_q.push_back(8'h00);
    read_check("rd0_data", 1'b1);
    check("rd0_released", 32'(sda_oe), 0);
    bus_stop();

    // Two-byte write starting at 3.
    set_ptr("wr", 8'h03);
    wr_q.push_back({4'h3, 8'h5A});
    write_byte(8'h5A, ack);
    check("wr_ack_5a", 32'(ack), 0);
    wr_q.push_back({4'h4, 8'hC3});
    write_byte(8'hC3, ack);
    check("wr_ack_c3", 32'(ack), 0);
    check("wr_busy_before_stop", 32'(busy), 1);
    bus_stop();
    check("wr_busy_after_stop", 32'(busy), 0);

    // Random read with master ACK then NACK.
    set_ptr("rr", 8'h03);
    bus_start();
    write_byte(8'hA1, ack);
    check("rr_rd_ack", 32'(ack), 0);
    rd_q.push_back(8'h5A);
    read_check("rr_data0", 1'b0);
    rd_q.push_back(8'hC3);
    read_check("rr_data1", 1'b1);
    check("rr_released", 32'(sda_oe), 0);
    check("rr_busy_idle", 32'(busy), 0);
    bus_stop();

    // Wrong device address: never drive SDA, never commit.
    oe_seen  = 1'b0;
    watch_oe = 1'b1;
    bus_start();
    write_byte(8'hA2, ack);
    check("wa_nack", 32'(ack), 1);
    write_byte(8'h03, ack);
    write_byte(8'h77, ack);
    bus_stop();
    watch_oe = 1'b0;
    check("wa_oe_never", 32'(oe_seen), 0);
    check("wa_busy", 32'(busy), 0);

    // Pointer wrap on write and on read.
    set_ptr("wrap_wr", 8'h0F);
    wr_q.push_back({4'hF, 8'h11});
    write_byte(8'h11, ack);
    check("wrap_ack_11", 32'(ack), 0);
    wr_q.push_back({4'h0, 8'h22});
    write_byte(8'h22, ack);
    check("wrap_ack_22", 32'(ack), 0);
    bus_stop();
    set_ptr("wrap_rd", 8'h0F);
    bus_start();
    write_byte(8'hA1, ack);
    rd_q.push_back(8'h11);
    read_check("wrap_rd_f", 1'b0);
    rd_q.push_back(8'h22);
    read_check("wrap_rd_0", 1'b1);
    bus_stop();
    bus_start();
    write_byte(8'hA1, ack);
    check("cur_rd_ack", 32'(ack), 0);
    rd_q.push_back(8'h22);
    read_check("cur_rd_ptr0", 1'b1);
    bus_stop();

    // STOP after 4 data bits discards the byte.
    set_ptr("abort", 8'h05);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    bus_stop();
    check("abort_busy", 32'(busy), 0);
    set_ptr("abort_rd", 8'h05);
    bus_start();
    write_byte(8'hA1, ack);
    check("abort_rd_ack", 32'(ack), 0);
    rd_q.push_back(8'h00);
    read_check("abort_mem5", 1'b1);
    bus_stop();

    // Reset while the DUT is driving a read bit (0x22 bit 7 = 0 pulls SDA).
    set_ptr("rstrd", 8'h00);
    bus_start();
    write_byte(8'hA1, ack);
    check("rstrd_rd_ack", 32'(ack), 0);
    check("rstrd_driving", 32'(sda_oe), 1);
    @(negedge clk);
    srst = 1'b1;
    @(posedge clk);
    #1;
    check("rstrd_released", 32'(sda_oe), 0);
    check("rstrd_busy", 32'(busy), 0);
    @(negedge clk);
    srst = 1'b0;
    bus_stop();
    repeat (10) @(negedge clk);

    check("wr_q_drained", 32'(wr_q.size()), 0);
    check("rd_q_drained", 32'(rd_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
